// File: rtl/int_commit_queue.sv
// Integer commit queue: takes up to NCH commits per cycle and drains NWR oldest to the register file.
// It also forwards the youngest pending write. Optional macro INT_COMMIT_BYPASS_EN lets groups that fit the wb ports skip an empty queue.
`ifndef XLEN
`define XLEN 64
`endif

module int_commit_queue_wbport #(
  parameter int NWR = 1,
  parameter int P   = 0
) (
  input  logic [NWR-1:0]      cand_v,
  input  logic [NWR-1:0][4:0] cand_idx,
  output logic                keep
);
  // a younger port writing the same register makes this write redundant
  always_comb begin
    keep = cand_v[P];
    for (int q = 0; q < NWR; q++)
      if (q > P && cand_v[q] && cand_idx[q] == cand_idx[P]) keep = 1'b0;
  end
endmodule

module int_commit_queue #(
  parameter int NCH   = 2,
  parameter int NWR   = 1,
  parameter int DEPTH = 8
) (
  input  logic                    clk_i,
  input  logic                    srstn_i,
  input  logic [NCH-1:0]          cmt_valid_i,
  input  logic [NCH-1:0]          cmt_wren_i,
  input  logic [NCH*`XLEN-1:0]    cmt_data_i,
  input  logic [NCH*5-1:0]        cmt_rdindex_i,
  output logic                    cmt_ready_o,
  output logic [NWR-1:0]          wb_valid_o,
  output logic [NWR*`XLEN-1:0]    wb_data_o,
  output logic [NWR*5-1:0]        wb_rdindex_o,
  input  logic [4:0]              lookup_index_i,
  output logic                    lookup_hit_o,
  output logic [`XLEN-1:0]        lookup_data_o,
  output logic [$clog2(DEPTH):0]  count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int XL = `XLEN;

  logic [DEPTH-1:0][XL-1:0] ent_data;
  logic [DEPTH-1:0][4:0]    ent_idx;
  logic [AW-1:0]            head, tail;
  logic [CW-1:0]            count, free, nq, nenq, ndeq;
  logic [NCH-1:0]           qual;
  logic [NCH-1:0][CW-1:0]   qpos;
  logic                     byp, acc;
  logic [NWR-1:0]           cand_v, keep;
  logic [NWR-1:0][4:0]      cand_idx;
  logic [NWR-1:0][XL-1:0]   cand_data;

  assign free        = CW'(DEPTH) - count;
  assign cmt_ready_o = free >= CW'(NCH);
  assign count_o     = count;

  // qpos[c] is the compacted slot offset of channel c among qualifying channels
  always_comb begin
    nq = '0;
    for (int c = 0; c < NCH; c++) begin
      qual[c] = cmt_valid_i[c] & cmt_wren_i[c] & (cmt_rdindex_i[c*5 +: 5] != 5'd0);
      qpos[c] = nq;
      nq      = nq + CW'(qual[c]);
    end
  end

`ifdef INT_COMMIT_BYPASS_EN
  assign byp = (count == '0) && (nq <= CW'(NWR));
`else
  assign byp = 1'b0;
`endif

  assign acc  = cmt_ready_o & ~byp;
  assign nenq = acc ? nq : '0;
  assign ndeq = (count < CW'(NWR)) ? count : CW'(NWR);

  always_comb begin
    cand_v    = '0;
    cand_idx  = '0;
    cand_data = '0;
    for (int p = 0; p < NWR; p++) begin
      cand_v[p]    = CW'(p) < ndeq;
      cand_idx[p]  = ent_idx[head + AW'(p)];
      cand_data[p] = ent_data[head + AW'(p)];
    end
    if (byp) begin
      cand_v = '0;
      for (int p = 0; p < NWR; p++)
        for (int c = 0; c < NCH; c++)
          if (qual[c] && qpos[c] == CW'(p)) begin
            cand_v[p]    = 1'b1;
            cand_idx[p]  = cmt_rdindex_i[c*5 +: 5];
            cand_data[p] = cmt_data_i[c*XL +: XL];
          end
    end
  end

  for (genvar p = 0; p < NWR; p++) begin : g_wb
    int_commit_queue_wbport #(.NWR(NWR), .P(p)) u_port (
      .cand_v   (cand_v),
      .cand_idx (cand_idx),
      .keep     (keep[p])
    );
    assign wb_valid_o[p]            = keep[p] & srstn_i;
    assign wb_data_o[p*XL +: XL]    = cand_data[p];
    assign wb_rdindex_o[p*5 +: 5]   = cand_idx[p];
  end

  // scan oldest to youngest so the last match wins; draining entries still count
  always_comb begin
    logic [AW-1:0] slot;
    lookup_hit_o  = 1'b0;
    lookup_data_o = '0;
    slot          = head;
    for (int i = 0; i < DEPTH; i++) begin
      slot = head + AW'(i);
      if (CW'(i) < count && lookup_index_i != 5'd0 && ent_idx[slot] == lookup_index_i) begin
        lookup_hit_o  = 1'b1;
        lookup_data_o = ent_data[slot];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!srstn_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + ndeq[AW-1:0];
      tail  <= tail + nenq[AW-1:0];
      count <= count + nenq - ndeq;
    end
  end

  // storage needs no reset: count alone decides which entries are live
  always_ff @(posedge clk_i) begin
    if (acc)
      for (int c = 0; c < NCH; c++)
        if (qual[c]) begin
          ent_data[tail + qpos[c][AW-1:0]] <= cmt_data_i[c*XL +: XL];
          ent_idx[tail + qpos[c][AW-1:0]]  <= cmt_rdindex_i[c*5 +: 5];
        end
  end
endmodule

// File: tb/tb_int_commit_queue.sv
// Randomized bench for int_commit_queue against a queue-based reference model, plus directed scenarios.
`ifndef XLEN
`define XLEN 64
`endif

module tb_int_commit_queue;
  localparam int NCH = 4, NWR = 2, DEPTH = 8, XL = `XLEN;
  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct { logic [4:0] idx; logic [XL-1:0] data; } ent_t;

  logic                 clk = 1'b0, srstn;
  logic [NCH-1:0]       cmt_valid, cmt_wren;
  logic [NCH*XL-1:0]    cmt_data;
  logic [NCH*5-1:0]     cmt_rdindex;
  logic                 cmt_ready;
  logic [NWR-1:0]       wb_valid;
  logic [NWR*XL-1:0]    wb_data;
  logic [NWR*5-1:0]     wb_rdindex;
  logic [4:0]           lookup_index;
  logic                 lookup_hit;
  logic [XL-1:0]        lookup_data;
  logic [CW-1:0]        count;

  int_commit_queue #(.NCH(NCH), .NWR(NWR), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .srstn_i(srstn),
    .cmt_valid_i(cmt_valid), .cmt_wren_i(cmt_wren), .cmt_data_i(cmt_data), .cmt_rdindex_i(cmt_rdindex),
    .cmt_ready_o(cmt_ready),
    .wb_valid_o(wb_valid), .wb_data_o(wb_data), .wb_rdindex_o(wb_rdindex),
    .lookup_index_i(lookup_index), .lookup_hit_o(lookup_hit), .lookup_data_o(lookup_data),
    .count_o(count)
  );

  always #5 clk = ~clk;

  int nchk = 0, nerr = 0;

  task automatic chk(input string tag, input logic [XL-1:0] got, input logic [XL-1:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // stimulus for the next cycle
  logic                   d_rst;
  logic [NCH-1:0]         d_v, d_w;
  logic [NCH-1:0][4:0]    d_ix;
  logic [NCH-1:0][XL-1:0] d_d;
  logic [4:0]             d_lk;

  // last observed outputs, for directed checks
  logic          o_rdy, o_hit;
  logic [CW-1:0] o_cnt;
  logic [NWR-1:0] o_wbv;
  logic [XL-1:0] o_ldata, o_wbd1;

  ent_t mq[$];

  task automatic set_idle();
    d_rst = 1'b1; d_v = '0; d_w = '0; d_ix = '0; d_d = '0; d_lk = '0;
  endtask

  task automatic tick();
    ent_t qe[$], cand[$];
    int sz, nd;
    bit rdy, byp, hit;
    logic [XL-1:0] ld;
    logic [NWR-1:0] ev;
    @(negedge clk);
    srstn = d_rst; cmt_valid = d_v; cmt_wren = d_w;
    cmt_rdindex = d_ix; cmt_data = d_d; lookup_index = d_lk;
    #1;
    sz  = mq.size();
    rdy = (DEPTH - sz) >= NCH;
    for (int c = 0; c < NCH; c++)
      if (d_v[c] && d_w[c] && d_ix[c] != 5'd0) qe.push_back('{d_ix[c], d_d[c]});
    byp = 1'b0;
`ifdef INT_COMMIT_BYPASS_EN
    byp = (sz == 0) && (qe.size() <= NWR);
`endif
    nd = byp ? 0 : ((sz < NWR) ? sz : NWR);
    if (byp) cand = qe;
    else for (int p = 0; p < nd; p++) cand.push_back(mq[p]);
    ev = '0;
    for (int p = 0; p < cand.size(); p++) begin
      ev[p] = 1'b1;
      for (int k = p + 1; k < cand.size(); k++)
        if (cand[k].idx == cand[p].idx) ev[p] = 1'b0;
    end
    if (!d_rst) ev = '0;
    hit = 1'b0; ld = '0;
    if (d_lk != 5'd0)
      for (int i = sz - 1; i >= 0; i--)
        if (mq[i].idx == d_lk) begin hit = 1'b1; ld = mq[i].data; break; end
    chk("ready", cmt_ready, rdy);
    chk("count", count, sz);
    chk("wb_valid", wb_valid, ev);
    for (int p = 0; p < NWR; p++)
      if (ev[p]) begin
        chk("wb_data", wb_data[p*XL +: XL], cand[p].data);
        chk("wb_idx", wb_rdindex[p*5 +: 5], cand[p].idx);
      end
    chk("lk_hit", lookup_hit, hit);
    chk("lk_data", lookup_data, ld);
    o_rdy = cmt_ready; o_cnt = count; o_wbv = wb_valid;
    o_hit = lookup_hit; o_ldata = lookup_data; o_wbd1 = wb_data[XL +: XL];
    @(posedge clk);
    if (!d_rst) mq.delete();
    else begin
      repeat (nd) void'(mq.pop_front());
      if (rdy && !byp) foreach (qe[k]) mq.push_back(qe[k]);
    end
  endtask

  initial begin
    set_idle(); d_rst = 1'b0;
    tick(); tick();
    set_idle(); tick();
    chk("post_rst_ready", o_rdy, 1);
    chk("post_rst_count", o_cnt, 0);
    chk("post_rst_hit", o_hit, 0);

    // filtering: no wren on ch0, index 0 on ch1
    d_v = 4'b0011; d_w = 4'b0010; d_ix[0] = 5'd5; d_ix[1] = 5'd0; d_d[0] = 'h55; d_d[1] = 'h66;
    tick();
    set_idle(); tick();
    chk("filt_count", o_cnt, 0);
    chk("filt_wbv", o_wbv, 0);

    // x3=A, x3=B, x9=C: forwarding returns B, same-cycle collision keeps only port 1
    d_v = 4'b0111; d_w = 4'b0111;
    d_ix[0] = 5'd3; d_d[0] = 'hA;
    d_ix[1] = 5'd3; d_d[1] = 'hB;
    d_ix[2] = 5'd9; d_d[2] = 'hC;
    tick();
    set_idle(); d_lk = 5'd3; tick();
    chk("fwd_count", o_cnt, 3);
    chk("fwd_hit", o_hit, 1);
    chk("fwd_data", o_ldata, 'hB);
    chk("coll_wbv", o_wbv, 2'b10);
    chk("coll_data", o_wbd1, 'hB);
    d_lk = 5'd0; tick();
    chk("coll_count", o_cnt, 1);
    chk("lk0_hit", o_hit, 0);
    set_idle(); tick();

    // fill until not ready, confirm the group is dropped
    d_v = '1; d_w = '1;
    for (int c = 0; c < NCH; c++) begin d_ix[c] = 5'(c + 1); d_d[c] = XL'($urandom); end
    tick(); tick(); tick();
    chk("full_count", o_cnt, 6);
    chk("full_ready", o_rdy, 0);
    tick();
    chk("drop_count", o_cnt, 4);
    tick();

    // reset mid-operation
    d_rst = 1'b0; tick();
    chk("rst_wbv", o_wbv, 0);
    set_idle(); tick();
    chk("rst_count", o_cnt, 0);
    chk("rst_ready", o_rdy, 1);
    chk("rst_wbv2", o_wbv, 0);

    for (int n = 0; n < 1000; n++) begin
      d_rst = ($urandom_range(0, 80) != 0);
      d_v   = NCH'($urandom);
      d_w   = NCH'($urandom | $urandom);
      for (int c = 0; c < NCH; c++) begin
        d_ix[c] = 5'($urandom_range(0, 7));
        d_d[c]  = XL'({$urandom, $urandom});
      end
      d_lk = 5'($urandom_range(0, 7));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
